// File: rtl/microprogram_sequencer_if.sv
// rtl/microprogram_sequencer_if.sv - sequencer-to-datapath bundle for the microprogram sequencer
interface microprogram_sequencer_if;
    // Inputs to the sequencer
    logic [15:0] next_addr;
    logic [1:0]  br_type;
    logic        z_flag;
    logic        wait_req;
    logic        mem_ready;
    logic        halt;
    logic        resume;
    // Outputs from the sequencer
    logic [15:0] upc;
    logic [15:0] inc_addr;
    logic [1:0]  select;
    logic        upc_valid;
    logic        halted;

    // The sequencer itself
    modport slave (
        input  next_addr,
        input  br_type,
        input  z_flag,
        input  wait_req,
        input  mem_ready,
        input  halt,
        input  resume,
        output upc,
        output inc_addr,
        output select,
        output upc_valid,
        output halted
    );

    // The surrounding control unit / next-address multiplexer
    modport master (
        output next_addr,
        output br_type,
        output z_flag,
        output wait_req,
        output mem_ready,
        output halt,
        output resume,
        input  upc,
        input  inc_addr,
        input  select,
        input  upc_valid,
        input  halted
    );
endinterface

// File: rtl/microprogram_sequencer.sv
// rtl/microprogram_sequencer.sv - micro-PC register, next-address select and run/stall/halt control
module microprogram_sequencer #(
    parameter logic [15:0] RESET_ADDR = 16'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    microprogram_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_INC  = 2'd0;
    localparam logic [1:0] SEL_JUMP = 2'd1;
    localparam logic [1:0] SEL_MAP  = 2'd2;

    localparam logic [1:0] BR_SEQ  = 2'd0;
    localparam logic [1:0] BR_JUMP = 2'd1;
    localparam logic [1:0] BR_MAP  = 2'd2;
    localparam logic [1:0] BR_JZ   = 2'd3;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] upc_q;
    logic [15:0] upc_d;
    logic [1:0]  select_c;

    // Branch decode for the next-address mux; a conditional jump falls back to the increment path
    always_comb begin
        select_c = SEL_INC;
        case (bus.br_type)
            BR_SEQ:  select_c = SEL_INC;
            BR_JUMP: select_c = SEL_JUMP;
            BR_MAP:  select_c = SEL_MAP;
            BR_JZ:   select_c = bus.z_flag ? SEL_JUMP : SEL_INC;
            default: select_c = SEL_INC;
        endcase
    end

    // Next state and next micro-PC; halt outranks both loading and stalling
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        case (state_q)
            ST_INIT: begin
                // One settling cycle: the reset address is presented but not executed yet
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.wait_req && !bus.mem_ready) begin
                    state_d = ST_STALL;
                end else begin
                    upc_d = bus.next_addr;
                end
            end
            ST_STALL: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.mem_ready) begin
                    state_d = ST_RUN;
                    upc_d   = bus.next_addr;
                end
            end
            ST_HALT: begin
                // Resuming does not load, so the held microinstruction executes again
                if (bus.resume && !bus.halt) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
                upc_d   = RESET_ADDR;
            end
        endcase
    end

    // State and micro-PC registers; reset abandons any pending stall or halt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            upc_q   <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
        end
    end

    assign bus.upc       = upc_q;
    assign bus.inc_addr  = upc_q + 16'd1;
    assign bus.select    = select_c;
    assign bus.upc_valid = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_microprogram_sequencer.sv
// tb/tb_microprogram_sequencer.sv - directed self-checking bench for microprogram_sequencer
module tb_microprogram_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    microprogram_sequencer_if bus ();

    microprogram_sequencer #(.RESET_ADDR(16'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.next_addr = 16'h0000;
        bus.br_type = 2'd0;
        bus.z_flag = 1'b0;
        bus.wait_req = 1'b0;
        bus.mem_ready = 1'b0;
        bus.halt = 1'b0;
        bus.resume = 1'b0;

        // Reset state before any clock edge
        #3;
        check("rst_upc", bus.upc, 16'h0000);
        check("rst_valid", bus.upc_valid, 16'd0);
        check("rst_halted", bus.halted, 16'd0);
        check("rst_inc", bus.inc_addr, 16'h0001);
        check("rst_sel_br0", bus.select, 16'd0);

        // Branch decode
        bus.br_type = 2'd3; bus.z_flag = 1'b1; #1;
        check("sel_jz_z1", bus.select, 16'd1);
        bus.z_flag = 1'b0; #1;
        check("sel_jz_z0", bus.select, 16'd0);
        bus.br_type = 2'd2; bus.z_flag = 1'b1; #1;
        check("sel_map_z1", bus.select, 16'd2);
        bus.z_flag = 1'b0; #1;
        check("sel_map_z0", bus.select, 16'd2);
        bus.br_type = 2'd1; #1;
        check("sel_jump", bus.select, 16'd1);
        bus.br_type = 2'd0;

        // Release reset between edges: INIT cycle, then sequential stepping
        tick();
        check("rst_hold_upc", bus.upc, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_upc", bus.upc, 16'h0000);
        check("init_valid", bus.upc_valid, 16'd0);
        bus.next_addr = 16'h0001;
        tick();
        check("run0_upc", bus.upc, 16'h0000);
        check("run0_valid", bus.upc_valid, 16'd1);
        tick();
        check("seq1_upc", bus.upc, 16'h0001);
        bus.next_addr = 16'h0002;
        tick();
        check("seq2_upc", bus.upc, 16'h0002);
        bus.next_addr = 16'h0003;
        tick();
        check("seq3_upc", bus.upc, 16'h0003);
        check("seq3_inc", bus.inc_addr, 16'h0004);

        // Wrap at the top of the address space
        bus.next_addr = 16'hFFFF;
        tick();
        check("wrap_upc", bus.upc, 16'hFFFF);
        check("wrap_inc", bus.inc_addr, 16'h0000);
        bus.next_addr = 16'h0000;
        tick();
        check("wrap_next_upc", bus.upc, 16'h0000);

        // Three-cycle stall, then load on the mem_ready edge
        bus.next_addr = 16'h0010;
        bus.wait_req = 1'b1; bus.mem_ready = 1'b0;
        tick();
        check("stall1_upc", bus.upc, 16'h0000);
        check("stall1_valid", bus.upc_valid, 16'd1);
        tick();
        check("stall2_upc", bus.upc, 16'h0000);
        tick();
        check("stall3_upc", bus.upc, 16'h0000);
        bus.mem_ready = 1'b1;
        tick();
        check("stall_done_upc", bus.upc, 16'h0010);

        // Access that completes immediately does not stall
        bus.next_addr = 16'h0020;
        tick();
        check("nostall_upc", bus.upc, 16'h0020);
        bus.next_addr = 16'h0021;
        bus.wait_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        check("run_0021", bus.upc, 16'h0021);

        // Enter STALL, then halt from STALL
        bus.next_addr = 16'h0042;
        bus.wait_req = 1'b1;
        tick();
        check("stall_b_upc", bus.upc, 16'h0021);
        bus.halt = 1'b1;
        tick();
        check("halt_upc", bus.upc, 16'h0021);
        check("halt_halted", bus.halted, 16'd1);
        check("halt_valid", bus.upc_valid, 16'd0);
        bus.halt = 1'b0; bus.mem_ready = 1'b1;
        tick();
        check("halt_hold_upc", bus.upc, 16'h0021);
        check("halt_hold_halted", bus.halted, 16'd1);
        bus.halt = 1'b1; bus.resume = 1'b1;
        tick();
        check("halt_both_halted", bus.halted, 16'd1);
        check("halt_both_upc", bus.upc, 16'h0021);
        bus.halt = 1'b0;
        tick();
        check("resume_upc", bus.upc, 16'h0021);
        check("resume_halted", bus.halted, 16'd0);
        check("resume_valid", bus.upc_valid, 16'd1);
        bus.wait_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        check("resume_ignored_upc", bus.upc, 16'h0042);
        check("resume_ignored_halted", bus.halted, 16'd0);
        bus.resume = 1'b0;

        // Halt from RUN at 0x0042, then asynchronous reset between edges
        bus.halt = 1'b1;
        bus.next_addr = 16'h0099;
        tick();
        check("halt_run_upc", bus.upc, 16'h0042);
        check("halt_run_halted", bus.halted, 16'd1);
        bus.halt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_upc", bus.upc, 16'h0000);
        check("async_rst_halted", bus.halted, 16'd0);
        check("async_rst_valid", bus.upc_valid, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_noload_upc", bus.upc, 16'h0000);
        check("post_rst_valid", bus.upc_valid, 16'd1);
        tick();
        check("post_rst_load_upc", bus.upc, 16'h0099);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
